// File: rtl/serial_add_sequencer.sv
// Operand FIFO, launch sequencer and result collector wrapped around a bit-serial adder.
// Optional macro SEQ_CHECK_EN adds a sticky reference check of every captured sum.
module serial_add_sequencer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned LATENCY = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             add_start,
  output logic [WIDTH-1:0] add_op1,
  output logic [WIDTH-1:0] add_op2,
  input  logic [WIDTH:0]   add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic             busy,
  output logic             chk_err
);

  localparam int unsigned SW = WIDTH + 1;
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] fifo_a [2];
  logic [WIDTH-1:0] fifo_b [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;
  logic [CW-1:0]    cnt;
  logic             push, launch, capture;

  // Depends only on the registered occupancy, never on the pop
  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign busy     = (count != 2'd0) || (state == RUN) || out_valid;

  // Launch only when the output slot is free or being drained this edge
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if ((count != 2'd0) && (!out_valid || out_ready)) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          capture    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      add_start <= 1'b0;
      cnt       <= '0;
      add_op1   <= '0;
      add_op2   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      state     <= state_next;
      add_start <= (state_next == RUN);
      if (launch) begin
        add_op1 <= fifo_a[rd_ptr];
        add_op2 <= fifo_b[rd_ptr];
        cnt     <= CW'(LATENCY - 1);
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      // A capture on the same edge as a consume keeps the slot full
      if (capture) begin
        out_valid <= 1'b1;
        out_sum   <= add_sum;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)   wr_ptr <= ~wr_ptr;
      if (launch) rd_ptr <= ~rd_ptr;
      count <= 2'(count + {1'b0, push} - {1'b0, launch});
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr] <= in_a;
      fifo_b[wr_ptr] <= in_b;
    end
  end

`ifdef SEQ_CHECK_EN
  logic [WIDTH:0] ref_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_sum <= '0;
      chk_err <= 1'b0;
    end else begin
      if (launch) ref_sum <= SW'(fifo_a[rd_ptr]) + SW'(fifo_b[rd_ptr]);
      if (capture && (add_sum != ref_sum)) chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Randomized bench for serial_add_sequencer with a behavioural serial-adder model and result scoreboard.
module tb_serial_add_sequencer;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned LATENCY = 9;

  logic             clk, reset;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             add_start;
  logic [WIDTH-1:0] add_op1, add_op2;
  logic [WIDTH:0]   add_sum;
  logic             out_valid, out_ready;
  logic [WIDTH:0]   out_sum;
  logic             busy, chk_err;

  serial_add_sequencer #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_start(add_start), .add_op1(add_op1), .add_op2(add_op2), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .chk_err(chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial adder model: sum is only correct during the LATENCY-th start cycle
  int  add_cnt;
  logic inject;
  always @(posedge clk or posedge reset) begin
    if (reset)          add_cnt <= 0;
    else if (add_start) add_cnt <= add_cnt + 1;
    else                add_cnt <= 0;
  end
  always_comb begin
    add_sum = 9'h155;
    if (add_start && add_cnt == LATENCY - 1) begin
      if (inject && add_op1 == 8'h03 && add_op2 == 8'h04) add_sum = 9'h000;
      else                                                add_sum = {1'b0, add_op1} + {1'b0, add_op2};
    end
  end

  logic [WIDTH:0] exp_q[$];
  int             hs_q[$];
  int             cyc = 0;
  int             run = 0;
  logic           prev_start = 1'b0;
  logic           prev_hold = 1'b0;
  logic [WIDTH:0] held_sum = '0;

  // Output scoreboard, start-pulse length and hold-stability checks
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      run = 0; prev_start = 1'b0; prev_hold = 1'b0;
    end else begin
      if (add_start) run++;
      else if (prev_start) begin
        check("start_run_len", run, LATENCY);
        run = 0;
      end
      prev_start = add_start;
      if (prev_hold && out_valid) check("out_sum_stable", out_sum, held_sum);
      prev_hold = out_valid && !out_ready;
      held_sum  = out_sum;
      if (out_valid && out_ready) begin
        hs_q.push_back(cyc);
        if (exp_q.size() == 0) check("unexpected_out", out_sum, 32'hDEAD);
        else                   check("out_sum", out_sum, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    while (!in_ready && n < 300) begin tick(); n++; end
    if (!in_ready) begin
      check("push_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 1000) begin tick(); n++; end
    check("drain_done", (exp_q.size() == 0 && !busy), 1);
  endtask

  logic prod_done;

  initial begin
    int j, starts, seen;
    logic [7:0] ra, rb;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; inject = 1'b0;
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_add_start", add_start, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_add_op", {add_op1, add_op2}, 0);
    check("rst_chk_err", chk_err, 0);
    reset = 1'b0;
    tick();

    // Single operation latency
    push(8'h01, 8'h01, 9'h002);
    j = 0; starts = 0;
    while (!out_valid && j < 30) begin
      if (add_start) starts++;
      tick(); j++;
    end
    check("first_latency", j, LATENCY + 1);
    check("start_cycles", starts, LATENCY);
    check("first_sum", out_sum, 9'h002);
    check("op1_held", add_op1, 8'h01);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("out_valid_clr", out_valid, 0);

    // Carry into MSB
    out_ready = 1'b1;
    push(8'hFF, 8'hFF, 9'h1FE);
    drain();

    // Backpressure: fill FIFO while the result slot is blocked
    out_ready = 1'b0;
    push(8'h0A, 8'h14, 9'h01E);
    push(8'h1E, 8'h28, 9'h046);
    push(8'h32, 8'h3C, 9'h06E);
    check("full_in_ready", in_ready, 0);
    fork
      push(8'h46, 8'h50, 9'h096);
      begin
        repeat (30) tick();
        check("bp_valid_held", out_valid, 1);
        check("bp_first_sum", out_sum, 9'h01E);
        check("bp_in_ready", in_ready, 0);
        hs_q.delete();
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_results", hs_q.size(), 4);
    for (int i = 1; i < hs_q.size(); i++) check("bp_throughput", hs_q[i] - hs_q[i-1], LATENCY + 1);

    // Randomized traffic with random backpressure
    prod_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 120; i++) begin
          ra = 8'($urandom); rb = 8'($urandom);
          push(ra, rb, {1'b0, ra} + {1'b0, rb});
          repeat ($urandom_range(0, 3)) tick();
        end
        prod_done = 1'b1;
      end
      begin
        int n = 0;
        while ((!prod_done || exp_q.size() != 0) && n < 20000) begin
          out_ready = 1'($urandom_range(0, 1));
          tick(); n++;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of an operation with one pair buffered
    out_ready = 1'b1;
    push(8'h11, 8'h22, 9'h033);
    push(8'h33, 8'h44, 9'h077);
    j = 0;
    while (!add_start && j < 50) begin tick(); j++; end
    repeat (3) tick();
    check("mid_run_start", add_start, 1);
    #1 reset = 1'b1;
    exp_q.delete();
    #1;
    check("mr_add_start", add_start, 0);
    check("mr_out_valid", out_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_in_ready", in_ready, 1);
    tick(); tick();
    reset = 1'b0;
    seen = 0;
    repeat (30) begin tick(); seen |= int'(out_valid | add_start | busy); end
    check("mr_no_result", seen, 0);

    // Adder fault detection
    inject = 1'b1;
    push(8'h03, 8'h04, 9'h000);
    drain();
`ifdef SEQ_CHECK_EN
    check("chk_err_set", chk_err, 1);
`else
    check("chk_err_set", chk_err, 0);
`endif
    push(8'h05, 8'h06, 9'h00B);
    drain();
`ifdef SEQ_CHECK_EN
    check("chk_err_sticky", chk_err, 1);
`else
    check("chk_err_sticky", chk_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
